up_counter: RTL and testbench

//  Mod-N up counter fed by the clk_gen divided output, in the fsys domain.
//  clk_gen_out is treated as a synchronous enable, never as a clock.

---
 rtl/up_counter_pkg.sv | 15 +
 rtl/up_counter_if.sv | 47 ++++
 rtl/up_counter_rise_det.sv | 26 ++
 rtl/up_counter.sv | 116 +++++++++++
 tb/tb_up_counter.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/up_counter_pkg.sv
// up_counter_pkg
//   Shared definitions for the mod-N up counter: state width, state type
//   and the state encoding (also visible on the debug state output).
package up_counter_pkg;

  localparam int STATE_W = 2;

  typedef logic [STATE_W-1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_RUN   = 2'd1;
  localparam state_t ST_PAUSE = 2'd2;
  localparam state_t ST_DONE  = 2'd3;

endpackage

// File: rtl/up_counter_if.sv
// up_counter_if
//   Control/status bundle of the up counter. The clock and reset are plain
//   ports on the counter itself and are not part of this bundle.
//   master : the controller side (drives tick/en/clr/load/max/oneshot).
//   slave  : the counter side (drives q/tc/ovf/state).
//   Signals
//     up_cnt_tick_in   divided clock output, used only as an enable
//     up_cnt_en        1 = count ticks, 0 = pause
//     up_cnt_clr       synchronous clear of count and flags
//     up_cnt_load      load up_cnt_load_val this cycle
//     up_cnt_load_val  value to load (saturated to up_cnt_max)
//     up_cnt_max       terminal value, modulus is max+1
//     up_cnt_oneshot   1 = stop at max, 0 = wrap
//     up_cnt_q         current count
//     up_cnt_tc        one-cycle terminal-count pulse
//     up_cnt_ovf       sticky wrap flag
//     up_cnt_state     FSM state for debug
interface up_counter_if #(
  parameter int WIDTH = 8
);
  import up_counter_pkg::*;

  logic             up_cnt_tick_in;
  logic             up_cnt_en;
  logic             up_cnt_clr;
  logic             up_cnt_load;
  logic [WIDTH-1:0] up_cnt_load_val;
  logic [WIDTH-1:0] up_cnt_max;
  logic             up_cnt_oneshot;
  logic [WIDTH-1:0] up_cnt_q;
  logic             up_cnt_tc;
  logic             up_cnt_ovf;
  state_t           up_cnt_state;

  modport master (
    output up_cnt_tick_in, up_cnt_en, up_cnt_clr, up_cnt_load,
           up_cnt_load_val, up_cnt_max, up_cnt_oneshot,
    input  up_cnt_q, up_cnt_tc, up_cnt_ovf, up_cnt_state
  );

  modport slave (
    input  up_cnt_tick_in, up_cnt_en, up_cnt_clr, up_cnt_load,
           up_cnt_load_val, up_cnt_max, up_cnt_oneshot,
    output up_cnt_q, up_cnt_tc, up_cnt_ovf, up_cnt_state
  );

endinterface

// File: rtl/up_counter_rise_det.sv
// rise_det
//   One-bit rising-edge detector for a signal already synchronous to clk_i.
//   Produces a single-cycle pulse on each 0->1 transition of in_i; a level
//   held high gives no further pulses. Also used for the board push-buttons.
//   Ports
//     clk_i    clock
//     rst_i    synchronous active-high reset
//     in_i     level input
//     pulse_o  one-cycle pulse, combinational from in_i and the delayed copy
module rise_det (
  input  logic clk_i,
  input  logic rst_i,
  input  logic in_i,
  output logic pulse_o
);

  logic in_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) in_q <= 1'b0;
    else       in_q <= in_i;
  end

  assign pulse_o = in_i & ~in_q;

endmodule

// File: rtl/up_counter.sv
// up_counter
//   Mod-(max+1) up counter in the fsys domain. Each rising edge of the
//   divided clock (bus.up_cnt_tick_in) is one count tick; it is used as an
//   enable only. Supports run/pause, clear, saturating load, free-run or
//   one-shot, a terminal-count pulse and a sticky wrap flag.
//   Ports
//     fsys        system clock
//     up_cnt_rst  synchronous active-high reset, overrides everything
//     bus         up_counter_if slave modport (controls in, status out)
//
//   state | meaning
//   IDLE  | out of reset or cleared with en=0; count holds
//   RUN   | counting ticks
//   PAUSE | en dropped while running; count holds, ticks ignored
//   DONE  | one-shot reached max; holds until clr, load or reset
module up_counter
  import up_counter_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic        fsys,
  input  logic        up_cnt_rst,
  up_counter_if.slave bus
);

  logic             tick;
  state_t           state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             tc_q, tc_d;
  logic             ovf_q, ovf_d;
  logic [WIDTH-1:0] load_sat;

  rise_det u_tick_det (
    .clk_i   (fsys),
    .rst_i   (up_cnt_rst),
    .in_i    (bus.up_cnt_tick_in),
    .pulse_o (tick)
  );

  // A load never places q above the terminal value.
  assign load_sat = (bus.up_cnt_load_val > bus.up_cnt_max) ? bus.up_cnt_max
                                                            : bus.up_cnt_load_val;

  always_ff @(posedge fsys) begin
    if (up_cnt_rst) begin
      state_q <= ST_IDLE;
      q_q     <= '0;
      tc_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      tc_q    <= tc_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (bus.up_cnt_clr) begin
      state_d = bus.up_cnt_en ? ST_RUN : ST_IDLE;
    end else if (bus.up_cnt_load) begin
      if (state_q == ST_DONE && bus.up_cnt_en) state_d = ST_RUN;
    end else begin
      unique case (state_q)
        ST_IDLE:  if (bus.up_cnt_en) state_d = ST_RUN;
        ST_RUN: begin
          if (!bus.up_cnt_en)
            state_d = ST_PAUSE;
          // q >= max also covers the case where max was lowered below q.
          else if (tick && bus.up_cnt_oneshot && q_q >= bus.up_cnt_max)
            state_d = ST_DONE;
        end
        ST_PAUSE: if (bus.up_cnt_en) state_d = ST_RUN;
        ST_DONE:  state_d = ST_DONE;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    q_d   = q_q;
    tc_d  = 1'b0;
    ovf_d = ovf_q;
    if (bus.up_cnt_clr) begin
      q_d   = '0;
      ovf_d = 1'b0;
    end else if (bus.up_cnt_load) begin
      q_d = load_sat;
    end else if (state_q == ST_RUN && bus.up_cnt_en && tick) begin
      if (q_q < bus.up_cnt_max) begin
        q_d = q_q + 1'b1;
      end else if (q_q == bus.up_cnt_max) begin
        tc_d = 1'b1;
        if (!bus.up_cnt_oneshot) begin
          q_d   = '0;
          ovf_d = 1'b1;
        end
      end else begin
        // max was lowered below q: no terminal-count pulse on this tick.
        if (bus.up_cnt_oneshot) begin
          q_d = bus.up_cnt_max;
        end else begin
          q_d   = '0;
          ovf_d = 1'b1;
        end
      end
    end
  end

  assign bus.up_cnt_q     = q_q;
  assign bus.up_cnt_tc    = tc_q;
  assign bus.up_cnt_ovf   = ovf_q;
  assign bus.up_cnt_state = state_q;

endmodule

// File: tb/tb_up_counter.sv
module tb_up_counter;
  import up_counter_pkg::*;

  logic fsys = 1'b0;
  logic up_cnt_rst;
  int   checks = 0;
  int   errors = 0;

  up_counter_if #(.WIDTH(8)) bus ();

  up_counter #(.WIDTH(8)) dut (
    .fsys       (fsys),
    .up_cnt_rst (up_cnt_rst),
    .bus        (bus)
  );

  always #5 fsys = ~fsys;

  task automatic cyc();
    @(posedge fsys);
    #1;
  endtask

  // One tick: tick_in high one cycle (sample q/tc), then low one cycle.
  task automatic tick(output logic [7:0] qv, output logic tcv);
    bus.up_cnt_tick_in = 1'b1;
    cyc();
    qv  = bus.up_cnt_q;
    tcv = bus.up_cnt_tc;
    bus.up_cnt_tick_in = 1'b0;
    cyc();
  endtask

  task automatic do_clr();
    bus.up_cnt_clr = 1'b1;
    cyc();
    bus.up_cnt_clr = 1'b0;
  endtask

  task automatic test_reset();
    bus.up_cnt_en = 1'b1; bus.up_cnt_max = 8'd9; bus.up_cnt_oneshot = 1'b0;
    up_cnt_rst = 1'b1;
    cyc(); cyc();
    checks++; if (bus.up_cnt_q !== 8'd0) begin errors++; $display("FAIL reset_q got %0d want 0", bus.up_cnt_q); end
    checks++; if (bus.up_cnt_tc !== 1'b0) begin errors++; $display("FAIL reset_tc got %0b want 0", bus.up_cnt_tc); end
    checks++; if (bus.up_cnt_ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf got %0b want 0", bus.up_cnt_ovf); end
    checks++; if (bus.up_cnt_state !== ST_IDLE) begin errors++; $display("FAIL reset_state got %0d want 0", bus.up_cnt_state); end
    up_cnt_rst = 1'b0;
    cyc();
    checks++; if (bus.up_cnt_state !== ST_RUN) begin errors++; $display("FAIL idle_to_run got %0d want 1", bus.up_cnt_state); end
  endtask

  task automatic test_free_run();
    logic [7:0] qv; logic tcv; logic [7:0] eq; logic etc;
    for (int k = 1; k <= 12; k++) begin
      tick(qv, tcv);
      eq  = (k <= 9) ? 8'(k) : 8'(k - 10);
      etc = (k == 10);
      checks++; if (qv !== eq) begin errors++; $display("FAIL free_q tick %0d got %0d want %0d", k, qv, eq); end
      checks++; if (tcv !== etc) begin errors++; $display("FAIL free_tc tick %0d got %0b want %0b", k, tcv, etc); end
    end
    checks++; if (bus.up_cnt_ovf !== 1'b1) begin errors++; $display("FAIL free_ovf got %0b want 1", bus.up_cnt_ovf); end
  endtask

  task automatic test_oneshot();
    logic [7:0] qv; logic tcv; logic [7:0] eq;
    bus.up_cnt_max = 8'd3; bus.up_cnt_oneshot = 1'b1;
    do_clr();
    checks++; if (bus.up_cnt_ovf !== 1'b0) begin errors++; $display("FAIL clr_ovf got %0b want 0", bus.up_cnt_ovf); end
    for (int k = 1; k <= 6; k++) begin
      tick(qv, tcv);
      eq = (k <= 3) ? 8'(k) : 8'd3;
      checks++; if (qv !== eq) begin errors++; $display("FAIL os_q tick %0d got %0d want %0d", k, qv, eq); end
      checks++; if (tcv !== (k == 4)) begin errors++; $display("FAIL os_tc tick %0d got %0b want %0b", k, tcv, (k == 4)); end
    end
    checks++; if (bus.up_cnt_state !== ST_DONE) begin errors++; $display("FAIL os_state got %0d want 3", bus.up_cnt_state); end
    checks++; if (bus.up_cnt_ovf !== 1'b0) begin errors++; $display("FAIL os_ovf got %0b want 0", bus.up_cnt_ovf); end
    bus.up_cnt_load = 1'b1; bus.up_cnt_load_val = 8'd1;
    cyc();
    bus.up_cnt_load = 1'b0;
    checks++; if (bus.up_cnt_state !== ST_RUN) begin errors++; $display("FAIL done_load_state got %0d want 1", bus.up_cnt_state); end
    checks++; if (bus.up_cnt_q !== 8'd1) begin errors++; $display("FAIL done_load_q got %0d want 1", bus.up_cnt_q); end
    bus.up_cnt_oneshot = 1'b0;
  endtask

  task automatic test_pause();
    logic [7:0] qv; logic tcv;
    bus.up_cnt_max = 8'd9;
    do_clr();
    for (int k = 0; k < 5; k++) tick(qv, tcv);
    checks++; if (qv !== 8'd5) begin errors++; $display("FAIL pause_pre_q got %0d want 5", qv); end
    bus.up_cnt_en = 1'b0;
    cyc();
    checks++; if (bus.up_cnt_state !== ST_PAUSE) begin errors++; $display("FAIL pause_state got %0d want 2", bus.up_cnt_state); end
    for (int k = 0; k < 4; k++) tick(qv, tcv);
    checks++; if (bus.up_cnt_q !== 8'd5) begin errors++; $display("FAIL pause_hold_q got %0d want 5", bus.up_cnt_q); end
    bus.up_cnt_en = 1'b1;
    cyc();
    checks++; if (bus.up_cnt_state !== ST_RUN) begin errors++; $display("FAIL resume_state got %0d want 1", bus.up_cnt_state); end
    tick(qv, tcv);
    checks++; if (qv !== 8'd6) begin errors++; $display("FAIL resume_q got %0d want 6", qv); end
  endtask

  task automatic test_load();
    logic [7:0] qv; logic tcv;
    bus.up_cnt_load = 1'b1; bus.up_cnt_load_val = 8'd200; bus.up_cnt_max = 8'd50;
    bus.up_cnt_tick_in = 1'b1;
    cyc();
    bus.up_cnt_load = 1'b0; bus.up_cnt_tick_in = 1'b0;
    cyc();
    checks++; if (bus.up_cnt_q !== 8'd50) begin errors++; $display("FAIL load_sat_q got %0d want 50", bus.up_cnt_q); end
    tick(qv, tcv);
    checks++; if (qv !== 8'd0) begin errors++; $display("FAIL load_wrap_q got %0d want 0", qv); end
    checks++; if (tcv !== 1'b1) begin errors++; $display("FAIL load_wrap_tc got %0b want 1", tcv); end
    checks++; if (bus.up_cnt_ovf !== 1'b1) begin errors++; $display("FAIL load_wrap_ovf got %0b want 1", bus.up_cnt_ovf); end
    tick(qv, tcv);
    bus.up_cnt_clr = 1'b1; bus.up_cnt_load = 1'b1; bus.up_cnt_load_val = 8'd30;
    cyc();
    bus.up_cnt_clr = 1'b0; bus.up_cnt_load = 1'b0;
    checks++; if (bus.up_cnt_q !== 8'd0) begin errors++; $display("FAIL clr_load_q got %0d want 0", bus.up_cnt_q); end
    checks++; if (bus.up_cnt_ovf !== 1'b0) begin errors++; $display("FAIL clr_load_ovf got %0b want 0", bus.up_cnt_ovf); end
  endtask

  task automatic test_level_and_max0();
    logic [7:0] qv; logic tcv;
    bus.up_cnt_max = 8'd9;
    do_clr();
    bus.up_cnt_tick_in = 1'b1;
    repeat (20) cyc();
    bus.up_cnt_tick_in = 1'b0;
    cyc();
    checks++; if (bus.up_cnt_q !== 8'd1) begin errors++; $display("FAIL level_q got %0d want 1", bus.up_cnt_q); end
    bus.up_cnt_max = 8'd0;
    do_clr();
    for (int k = 1; k <= 3; k++) begin
      tick(qv, tcv);
      checks++; if (qv !== 8'd0) begin errors++; $display("FAIL max0_q tick %0d got %0d want 0", k, qv); end
      checks++; if (tcv !== 1'b1) begin errors++; $display("FAIL max0_tc tick %0d got %0b want 1", k, tcv); end
    end
    checks++; if (bus.up_cnt_ovf !== 1'b1) begin errors++; $display("FAIL max0_ovf got %0b want 1", bus.up_cnt_ovf); end
    bus.up_cnt_oneshot = 1'b1;
    tick(qv, tcv);
    checks++; if (tcv !== 1'b1) begin errors++; $display("FAIL max0_os_tc got %0b want 1", tcv); end
    checks++; if (bus.up_cnt_state !== ST_DONE) begin errors++; $display("FAIL max0_os_state got %0d want 3", bus.up_cnt_state); end
    bus.up_cnt_oneshot = 1'b0;
  endtask

  task automatic test_max_lower();
    logic [7:0] qv; logic tcv;
    bus.up_cnt_max = 8'd9;
    do_clr();
    for (int k = 0; k < 7; k++) tick(qv, tcv);
    bus.up_cnt_max = 8'd4;
    tick(qv, tcv);
    checks++; if (qv !== 8'd0) begin errors++; $display("FAIL lower_fr_q got %0d want 0", qv); end
    checks++; if (tcv !== 1'b0) begin errors++; $display("FAIL lower_fr_tc got %0b want 0", tcv); end
    checks++; if (bus.up_cnt_ovf !== 1'b1) begin errors++; $display("FAIL lower_fr_ovf got %0b want 1", bus.up_cnt_ovf); end
    bus.up_cnt_max = 8'd9;
    do_clr();
    for (int k = 0; k < 7; k++) tick(qv, tcv);
    bus.up_cnt_max = 8'd4; bus.up_cnt_oneshot = 1'b1;
    tick(qv, tcv);
    checks++; if (qv !== 8'd4) begin errors++; $display("FAIL lower_os_q got %0d want 4", qv); end
    checks++; if (tcv !== 1'b0) begin errors++; $display("FAIL lower_os_tc got %0b want 0", tcv); end
    checks++; if (bus.up_cnt_state !== ST_DONE) begin errors++; $display("FAIL lower_os_state got %0d want 3", bus.up_cnt_state); end
    checks++; if (bus.up_cnt_ovf !== 1'b0) begin errors++; $display("FAIL lower_os_ovf got %0b want 0", bus.up_cnt_ovf); end
    bus.up_cnt_oneshot = 1'b0;
  endtask

  task automatic test_mid_reset();
    logic [7:0] qv; logic tcv;
    bus.up_cnt_max = 8'd9;
    do_clr();
    for (int k = 0; k < 17; k++) tick(qv, tcv);
    checks++; if (qv !== 8'd7) begin errors++; $display("FAIL mid_pre_q got %0d want 7", qv); end
    checks++; if (bus.up_cnt_ovf !== 1'b1) begin errors++; $display("FAIL mid_pre_ovf got %0b want 1", bus.up_cnt_ovf); end
    up_cnt_rst = 1'b1; bus.up_cnt_tick_in = 1'b1;
    cyc();
    checks++; if (bus.up_cnt_q !== 8'd0) begin errors++; $display("FAIL mid_rst_q got %0d want 0", bus.up_cnt_q); end
    checks++; if (bus.up_cnt_tc !== 1'b0) begin errors++; $display("FAIL mid_rst_tc got %0b want 0", bus.up_cnt_tc); end
    checks++; if (bus.up_cnt_ovf !== 1'b0) begin errors++; $display("FAIL mid_rst_ovf got %0b want 0", bus.up_cnt_ovf); end
    checks++; if (bus.up_cnt_state !== ST_IDLE) begin errors++; $display("FAIL mid_rst_state got %0d want 0", bus.up_cnt_state); end
    up_cnt_rst = 1'b0; bus.up_cnt_tick_in = 1'b0;
    cyc();
  endtask

  initial begin
    up_cnt_rst          = 1'b1;
    bus.up_cnt_tick_in  = 1'b0;
    bus.up_cnt_en       = 1'b0;
    bus.up_cnt_clr      = 1'b0;
    bus.up_cnt_load     = 1'b0;
    bus.up_cnt_load_val = 8'd0;
    bus.up_cnt_max      = 8'd9;
    bus.up_cnt_oneshot  = 1'b0;
    test_reset();
    test_free_run();
    test_oneshot();
    test_pause();
    test_load();
    test_level_and_max0();
    test_max_lower();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
